green_pipe_stage: RTL
=====================

Name: green_pipe_stage

Overview:
- Parametrised, registered successor to the green execute/memory stage of the Justin-Beamformer datapath.
- Executes INC/DEC, load, store and conditional branch on operands A/B.
- Uses an internal synchronous-read data RAM and a valid/ready handshake on both sides, so upstream and downstream stages can stall.
- Output is fully registered: one-cycle latency for ALU, store and branch ops; two-cycle latency for loads.

Parameters:
DATA_W, 16, operand/result and RAM word width (≥4)
ADDR_W, 8, RAM address width; depth = 2**ADDR_W; 1..11

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage accepts an instruction this cycle
opCode  in  16  instruction word
A_in  in  DATA_W  operand A
B_in  in  DATA_W  operand B
ZNC_in  in  3  flags {Z,N,C} from the previous op
out_valid  out  1  registered result valid
out_ready  in  1  downstream accepts the result
A_out  out  DATA_W  result A
B_out  out  DATA_W  result B
ZNC_out  out  3  result flags
BR_out  out  1  branch taken

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low. RAM contents are not reset.
- Reset: state=IDLE, out_valid=0, A_out=0, B_out=0, ZNC_out=0, BR_out=0.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Decoding: op=opCode[15:12]; addr=opCode[ADDR_W-1:0]; mask=opCode[2:0].
- 0x0 NOP: outputs = inputs; ZNC_out=ZNC_in; BR_out=0.
- 0x1 INCA / 0x2 INCB: the selected operand +1, modulo 2**DATA_W. Z=(res==0), N=res[MSB], C=carry out. The other operand passes through.
- 0x3 DECA / 0x4 DECB: the selected operand −1. C=borrow, i.e. 1 when the operand was 0 (result wraps to all ones). Z and N as for INC.
- 0x5 LDA / 0x6 LDB: read RAM[addr] and load it into the selected operand. ZNC_out=ZNC_in.
- 0x7 STA / 0x8 STB: RAM[addr] is written with the selected operand on the accept edge. A/B pass through; ZNC_out=ZNC_in.
- 0x9 BR: BR_out = (mask==0) || |(mask & ZNC_in). A/B and ZNC pass through.
- 0xA–0xF: treated as NOP.
- BR_out=0 for every op except BR.
- FSM, IDLE → LOAD:
  - Entered on accepting LDA/LDB. The RAM read is issued at the accept edge.
  - In LOAD, in_ready=0. The next edge captures the RAM data into the output register, sets out_valid=1 and returns to IDLE.
- All other ops stay in IDLE. Their output register is loaded on the accept edge and out_valid=1 from the next cycle.
- Output hold: while out_valid && !out_ready, all outputs are held stable and no new accept occurs.
- Back-to-back throughput: when out_ready=1 continuously, non-load ops run at 1 per cycle and loads at 1 per 2 cycles.
- out_valid clears on an out_ready handshake when no new result arrives in the same cycle.
- Store followed by load of the same addr: the load returns the stored value (write precedes read by ≥1 edge).
- Reset asserted mid-LOAD: the load is abandoned, state=IDLE, out_valid=0. A store already accepted remains in RAM.

Optional Feature:
- Macro: GREEN_LDST_POSTINC_EN
- When defined, LD/ST ops with opCode[11]=1 use B_in[ADDR_W-1:0] as the address instead of the opCode field.
  - B_out = B_in+1, wrapping at 2**DATA_W.
  - LDB with opCode[11]=1 writes the loaded data to B_out; the post-increment is discarded.
  - ZNC_out=ZNC_in.
- When not defined, opCode[11] is ignored, addressing is always direct, and B is unmodified except by LDB/INCB/DECB.

Test Plan:
- Reset: assert rst_n=0 mid-run → all outputs 0, out_valid=0, in_ready=1 one cycle after release.
- INCA with A_in=16'hFFFF → one cycle later: A_out=0, ZNC_out=3'b101, out_valid=1. DECB with B_in=0 → B_out=16'hFFFF, ZNC_out=3'b011.
- STA with A=16'h1234 to addr 8'h10, then LDB from 8'h10 → B_out=16'h1234 two cycles after the LDB accept; in_ready=0 during the LOAD cycle.
- BR with mask=3'b100: ZNC_in=3'b100 → BR_out=1; ZNC_in=3'b011 → BR_out=0. mask=0 → BR_out=1.
- Backpressure: hold out_ready=0 for 3 cycles after an INCA result → outputs stable, in_ready=0. Release → next instruction is accepted in the same cycle.
- With GREEN_LDST_POSTINC_EN: STA (opCode[11]=1) with B=16'h00FF, ADDR_W=8 → RAM[8'hFF] written, B_out=16'h0100. Without the macro, the same op writes RAM[opCode[7:0]] and B_out=16'h00FF.

Source files
------------

// File: rtl/green_pipe_stage_if.sv
// green_pipe_stage_if: upstream/downstream handshake and data bundle for green_pipe_stage.
//   Upstream side : in_valid, in_ready, opCode[15:0], A_in, B_in, ZNC_in[2:0] ({Z,N,C})
//   Downstream    : out_valid, out_ready, A_out, B_out, ZNC_out[2:0], BR_out
// The master modport drives instructions and accepts results (testbench or pipeline glue).
// The slave modport is the stage itself.
interface green_pipe_stage_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       opCode;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic [2:0]        ZNC_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] A_out;
  logic [DATA_W-1:0] B_out;
  logic [2:0]        ZNC_out;
  logic              BR_out;

  modport master (
    output in_valid, opCode, A_in, B_in, ZNC_in, out_ready,
    input  in_ready, out_valid, A_out, B_out, ZNC_out, BR_out
  );

  modport slave (
    input  in_valid, opCode, A_in, B_in, ZNC_in, out_ready,
    output in_ready, out_valid, A_out, B_out, ZNC_out, BR_out
  );
endinterface

// File: rtl/green_pipe_stage.sv
// green_pipe_stage: registered execute/memory stage with an internal data RAM.
// Ops (opCode[15:12]): 0 NOP, 1 INCA, 2 INCB, 3 DECA, 4 DECB, 5 LDA, 6 LDB, 7 STA, 8 STB,
// 9 BR, A-F NOP. Address = opCode[ADDR_W-1:0], branch mask = opCode[2:0].
// Latency: one cycle for non-load ops, two cycles for loads (sync-read RAM, then capture).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (RAM contents are not reset)
//   bus    - green_pipe_stage_if.slave: valid/ready in, valid/ready out, operands and flags
// Optional: define GREEN_LDST_POSTINC_EN to let LD/ST with opCode[11]=1 address RAM by
// B_in[ADDR_W-1:0] and return B_out = B_in + 1 (LDB still overwrites B_out with load data).
module green_pipe_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  green_pipe_stage_if.slave    bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] OneW = DATA_W'(1);

  localparam logic [3:0] OpIncA = 4'h1;
  localparam logic [3:0] OpIncB = 4'h2;
  localparam logic [3:0] OpDecA = 4'h3;
  localparam logic [3:0] OpDecB = 4'h4;
  localparam logic [3:0] OpLdA  = 4'h5;
  localparam logic [3:0] OpLdB  = 4'h6;
  localparam logic [3:0] OpStA  = 4'h7;
  localparam logic [3:0] OpStB  = 4'h8;
  localparam logic [3:0] OpBr   = 4'h9;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [2:0]        znc_q, znc_d;
  logic              br_q, br_d;
  logic              ld_b_q, ld_b_d;   // pending load targets B
  logic [DATA_W-1:0] rd_data_q;        // RAM read register
  logic [DATA_W-1:0] mem_q [Depth];

  logic [3:0]        op;
  logic [2:0]        mask;
  logic              in_ready;
  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              postinc;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W:0]   inc_sum;
  logic [DATA_W-1:0] dec_res;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic [2:0]        res_znc;
  logic              res_br;
  logic              unused_op;

  assign unused_op = ^bus.opCode;

  // Decode and handshake
  always_comb begin
    op       = bus.opCode[15:12];
    mask     = bus.opCode[2:0];
    in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    is_load  = (op == OpLdA) || (op == OpLdB);
    is_store = (op == OpStA) || (op == OpStB);
`ifdef GREEN_LDST_POSTINC_EN
    postinc  = bus.opCode[11] && (is_load || is_store);
    addr     = postinc ? bus.B_in[ADDR_W-1:0] : bus.opCode[ADDR_W-1:0];
`else
    postinc  = 1'b0;
    addr     = bus.opCode[ADDR_W-1:0];
`endif
    st_data  = (op == OpStB) ? bus.B_in : bus.A_in;
  end

  // Result computation for the instruction being accepted
  always_comb begin
    opnd    = ((op == OpIncB) || (op == OpDecB)) ? bus.B_in : bus.A_in;
    inc_sum = {1'b0, opnd} + {1'b0, OneW};
    dec_res = opnd - OneW;

    res_a   = bus.A_in;
    res_b   = postinc ? (bus.B_in + OneW) : bus.B_in;
    res_znc = bus.ZNC_in;
    res_br  = 1'b0;

    case (op)
      OpIncA, OpIncB: begin
        if (op == OpIncA) res_a = inc_sum[DATA_W-1:0];
        else              res_b = inc_sum[DATA_W-1:0];
        res_znc = {(inc_sum[DATA_W-1:0] == '0), inc_sum[DATA_W-1], inc_sum[DATA_W]};
      end
      OpDecA, OpDecB: begin
        if (op == OpDecA) res_a = dec_res;
        else              res_b = dec_res;
        // Borrow only when decrementing zero
        res_znc = {(dec_res == '0), dec_res[DATA_W-1], (opnd == '0)};
      end
      OpBr: res_br = (mask == 3'b000) || (|(mask & bus.ZNC_in));
      default: ;
    endcase
  end

  // Next-state: outputs load on accept; loads leave out_valid low until the RAM data lands
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    znc_d       = znc_q;
    br_d        = br_q;
    ld_b_d      = ld_b_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d   = res_a;
          b_d   = res_b;
          znc_d = res_znc;
          br_d  = res_br;
          if (is_load) begin
            state_d     = StLoad;
            out_valid_d = 1'b0;
            ld_b_d      = (op == OpLdB);
          end else begin
            out_valid_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      StLoad: begin
        state_d     = StIdle;
        out_valid_d = 1'b1;
        if (ld_b_q) b_d = rd_data_q;
        else        a_d = rd_data_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      znc_q       <= '0;
      br_q        <= 1'b0;
      ld_b_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      znc_q       <= znc_d;
      br_q        <= br_d;
      ld_b_q      <= ld_b_d;
    end
  end

  // Data RAM: write and synchronous read both happen on the accept edge
  always_ff @(posedge clk) begin
    if (accept && is_store) mem_q[addr] <= st_data;
    if (accept && is_load)  rd_data_q   <= mem_q[addr];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.A_out     = a_q;
  assign bus.B_out     = b_q;
  assign bus.ZNC_out   = znc_q;
  assign bus.BR_out    = br_q;

endmodule
